// File: rtl/gold_symbol_scrambler_if.sv
// Symbol stream and control bundle for gold_symbol_scrambler.
// Names follow the scrambler's port list; master drives stimulus.
interface gold_symbol_scrambler_if #(
  parameter int DATA_W = 8
) ();
  logic                     i_start;
  logic [17:0]              i_code_n;
  logic                     i_in_valid;
  logic                     o_in_ready;
  logic signed [DATA_W-1:0] i_in_i;
  logic signed [DATA_W-1:0] i_in_q;
  logic                     o_out_valid;
  logic                     i_out_ready;
  logic signed [DATA_W-1:0] o_out_i;
  logic signed [DATA_W-1:0] o_out_q;
  logic                     o_out_last;
  logic [1:0]               o_out_rn;
  logic                     o_busy;

  modport master (
    output i_start, i_code_n,
    output i_in_valid, i_in_i, i_in_q,
    output i_out_ready,
    input  o_in_ready,
    input  o_out_valid, o_out_i, o_out_q,
    input  o_out_last, o_out_rn, o_busy
  );

  modport slave (
    input  i_start, i_code_n,
    input  i_in_valid, i_in_i, i_in_q,
    input  i_out_ready,
    output o_in_ready,
    output o_out_valid, o_out_i, o_out_q,
    output o_out_last, o_out_rn, o_busy
  );
endinterface

// File: rtl/gold_symbol_scrambler.sv
// Gold-sequence QPSK symbol scrambler: rotates each symbol by Rn*90 deg,
// code index pre-advances x, frames marked with o_out_last.
module gold_symbol_scrambler #(
  parameter int DATA_W       = 8,
  parameter int FRAME_LEN    = 16200,
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  gold_symbol_scrambler_if.slave  bus
);
  localparam int CW =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX =
    CW'(FRAME_LEN - 1);

  localparam logic [17:0] X_SEED = 18'h00001;
  localparam logic [17:0] Y_SEED = 18'h3FFFF;

  localparam logic signed [DATA_W-1:0] S_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] S_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEED = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [17:0]              x_q, x_d;
  logic [17:0]              y_q, y_d;
  logic [17:0]              down_q, down_d;
  logic [17:0]              code_q, code_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic [1:0]               rn_q, rn_d;
  logic signed [DATA_W-1:0] oi_q, oi_d;
  logic signed [DATA_W-1:0] oq_q, oq_d;

  logic [17:0]              x_nxt, y_nxt;
  logic [1:0]               rn;
  logic                     in_ready, accept;
  logic signed [DATA_W-1:0] rot_i, rot_q;

  function automatic logic signed [DATA_W-1:0] sneg(
    input logic signed [DATA_W-1:0] v
  );
    return (v == S_MIN) ? S_MAX : -v;
  endfunction

  assign x_nxt = {x_q[7] ^ x_q[0], x_q[17:1]};
  assign y_nxt = {y_q[10] ^ y_q[7] ^ y_q[5] ^ y_q[0],
                  y_q[17:1]};

  assign rn = {x_q[4] ^ x_q[6] ^ x_q[15] ^
               y_q[5] ^ y_q[6] ^ (^y_q[15:8]),
               x_q[0] ^ y_q[0]};

  assign in_ready = (state_q == S_RUN) &&
                    (!valid_q || bus.i_out_ready);
  assign accept   = bus.i_in_valid && in_ready;

  always_comb begin
    rot_i = bus.i_in_i;
    rot_q = bus.i_in_q;
    unique case (1'b1)
      rn == 2'd0: begin
        rot_i = bus.i_in_i;
        rot_q = bus.i_in_q;
      end
      rn == 2'd1: begin
        rot_i = sneg(bus.i_in_q);
        rot_q = bus.i_in_i;
      end
      rn == 2'd2: begin
        rot_i = sneg(bus.i_in_i);
        rot_q = sneg(bus.i_in_q);
      end
      rn == 2'd3: begin
        rot_i = bus.i_in_q;
        rot_q = sneg(bus.i_in_i);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    down_d  = down_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    rn_d    = rn_q;
    oi_d    = oi_q;
    oq_d    = oq_q;
    if (bus.i_start) begin
      code_d  = bus.i_code_n;
      down_d  = bus.i_code_n;
      x_d     = X_SEED;
      y_d     = Y_SEED;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = S_SEED;
    end else begin
      if (valid_q && bus.i_out_ready) valid_d = 1'b0;
      unique case (1'b1)
        state_q == S_SEED: begin
          if (down_q != 18'd0) begin
            x_d    = x_nxt;
            down_d = down_q - 18'd1;
          end else begin
            state_d = S_RUN;
          end
        end
        state_q == S_RUN: begin
          if (accept) begin
            x_d     = x_nxt;
            y_d     = y_nxt;
            valid_d = 1'b1;
            oi_d    = rot_i;
            oq_d    = rot_q;
            rn_d    = rn;
            last_d  = (cnt_q == LAST_IDX);
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              cnt_d = '0;
              // Fresh seeds make every frame scramble identically
              if (AUTO_RESTART) begin
                x_d     = X_SEED;
                y_d     = Y_SEED;
                down_d  = code_q;
                state_d = S_SEED;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      x_q     <= X_SEED;
      y_q     <= Y_SEED;
      down_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rn_q    <= '0;
      oi_q    <= '0;
      oq_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      down_q  <= down_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rn_q    <= rn_d;
      oi_q    <= oi_d;
      oq_q    <= oq_d;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_out_valid = valid_q;
  assign bus.o_out_i     = oi_q;
  assign bus.o_out_q     = oq_q;
  assign bus.o_out_last  = last_q;
  assign bus.o_out_rn    = rn_q;
  assign bus.o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_gold_symbol_scrambler.sv
// Bench for gold_symbol_scrambler: vector table, directed corners and
// random traffic against an index-based Gold/rotation reference.
module tb_gold_symbol_scrambler;
  localparam int W  = 8;
  localparam int FL = 4;

  logic clk;
  logic rst;

  gold_symbol_scrambler_if #(.DATA_W(W)) bus ();
  gold_symbol_scrambler_if #(.DATA_W(W)) b2 ();

  gold_symbol_scrambler #(
    .DATA_W(W), .FRAME_LEN(FL), .AUTO_RESTART(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  gold_symbol_scrambler #(
    .DATA_W(W), .FRAME_LEN(3), .AUTO_RESTART(1'b0)
  ) dut2 (
    .i_clk(clk), .i_reset(rst), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] i;
    logic signed [7:0] q;
    int                rn;
    bit                last;
  } exp_t;

  typedef struct {
    int n; int k; int i; int q; int ei; int eq; int rn;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  bit   running;
  int   seed_left;
  int   cur_n;
  int   kidx;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Rn of symbol k in a frame for code n, from the sequence definition
  function automatic int gold_rn(input int n, input int k);
    logic [17:0] x;
    logic [17:0] y;
    x = 18'h00001;
    y = 18'h3FFFF;
    for (int s = 0; s < n + k; s++) x = {x[7] ^ x[0], x[17:1]};
    for (int s = 0; s < k; s++)
      y = {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
    return {30'd0,
            x[4] ^ x[6] ^ x[15] ^ y[5] ^ y[6] ^ y[8] ^ y[9] ^
            y[10] ^ y[11] ^ y[12] ^ y[13] ^ y[14] ^ y[15],
            x[0] ^ y[0]};
  endfunction

  function automatic logic signed [7:0] sat(input int v);
    if (v > 127) return 8'sd127;
    if (v < -128) return -8'sd128;
    return 8'(v);
  endfunction

  // Multiply (I + jQ) by j^rn, then clamp to the signed range
  function automatic exp_t model_out(input int i, input int q,
                                     input int rn, input bit last);
    exp_t e;
    int   c;
    int   s;
    c = (rn == 0) ? 1 : (rn == 2) ? -1 : 0;
    s = (rn == 1) ? 1 : (rn == 3) ? -1 : 0;
    e.i    = sat(i * c - q * s);
    e.q    = sat(i * s + q * c);
    e.rn   = rn;
    e.last = last;
    return e;
  endfunction

  task automatic step(input bit v, input int di, input int dq,
                      input bit ordy, output bit acc);
    bit rdy_e;
    bit fire;
    bus.i_in_valid  = v;
    bus.i_in_i      = 8'(di);
    bus.i_in_q      = 8'(dq);
    bus.i_out_ready = ordy;
    #1;
    rdy_e = running && seed_left == 0 &&
            (exp_q.size() == 0 || ordy);
    chk("in_ready", bus.o_in_ready, rdy_e);
    chk("out_valid", bus.o_out_valid, exp_q.size() != 0);
    chk("busy", bus.o_busy, running);
    if (exp_q.size() != 0) begin
      chk("out_i", bus.o_out_i, exp_q[0].i);
      chk("out_q", bus.o_out_q, exp_q[0].q);
      chk("out_rn", bus.o_out_rn, exp_q[0].rn);
      chk("out_last", bus.o_out_last, exp_q[0].last);
    end
    acc  = v && rdy_e;
    fire = exp_q.size() != 0 && ordy;
    @(posedge clk);
    #1;
    if (fire) void'(exp_q.pop_front());
    if (seed_left > 0) begin
      seed_left--;
    end else if (acc) begin
      exp_q.push_back(model_out(di, dq, gold_rn(cur_n, kidx),
                                kidx == FL - 1));
      if (kidx == FL - 1) begin
        kidx      = 0;
        seed_left = cur_n + 1;
      end else begin
        kidx++;
      end
    end
  endtask

  task automatic feed(input int di, input int dq);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 80 && !acc; t++) step(1'b1, di, dq, 1'b1, acc);
    if (!acc) chk("feed_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles, input bit ordy);
    bit acc;
    for (int c = 0; c < cycles; c++) step(1'b0, 0, 0, ordy, acc);
  endtask

  task automatic do_start(input int n, input bit ordy);
    bus.i_start     = 1'b1;
    bus.i_code_n    = 18'(n);
    bus.i_in_valid  = 1'($urandom_range(0, 1));
    bus.i_in_i      = 8'($urandom);
    bus.i_in_q      = 8'($urandom);
    bus.i_out_ready = ordy;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    exp_q.delete();
    running   = 1'b1;
    seed_left = n + 1;
    cur_n     = n;
    kidx      = 0;
  endtask

  task automatic do_reset();
    bus.i_start     = 1'b0;
    bus.i_in_valid  = 1'b0;
    bus.i_out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    running   = 1'b0;
    seed_left = 0;
    kidx      = 0;
    chk("rst_valid", bus.o_out_valid, 0);
    chk("rst_ready", bus.o_in_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_i", bus.o_out_i, 0);
    chk("rst_q", bus.o_out_q, 0);
    chk("rst_last", bus.o_out_last, 0);
    chk("rst_rn", bus.o_out_rn, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    bit   acc;
    exp_t e;
    int   r;

    tbl[0] = '{n: 0,  k: 0, i: 10,   q: 20,   ei: 10,  eq: 20,   rn: 0};
    tbl[1] = '{n: 0,  k: 1, i: 10,   q: 20,   ei: -20, eq: 10,   rn: 1};
    tbl[2] = '{n: 3,  k: 0, i: 5,    q: -7,   ei: -7,  eq: -5,   rn: 3};
    tbl[3] = '{n: 15, k: 3, i: -128, q: 40,   ei: 127, eq: -40,  rn: 2};
    tbl[4] = '{n: 14, k: 0, i: -128, q: -128, ei: 127, eq: -128, rn: 1};
    tbl[5] = '{n: 3,  k: 0, i: -128, q: 127,  ei: 127, eq: 127,  rn: 3};
    tbl[6] = '{n: 18, k: 0, i: 0,    q: -1,   ei: 0,   eq: -1,   rn: 0};

    b2.i_start     = 1'b0;
    b2.i_code_n    = '0;
    b2.i_in_valid  = 1'b0;
    b2.i_in_i      = '0;
    b2.i_in_q      = '0;
    b2.i_out_ready = 1'b0;
    bus.i_code_n   = '0;
    bus.i_in_i     = '0;
    bus.i_in_q     = '0;
    do_reset();
    idle(2, 1'b1);

    for (int v = 0; v < 7; v++) begin
      do_start(tbl[v].n, 1'b1);
      for (int j = 0; j < tbl[v].k; j++) feed(0, 0);
      feed(tbl[v].i, tbl[v].q);
      chk("tbl_i", bus.o_out_i, tbl[v].ei);
      chk("tbl_q", bus.o_out_q, tbl[v].eq);
      chk("tbl_rn", bus.o_out_rn, tbl[v].rn);
    end

    // Two back-to-back frames with auto restart
    do_start(0, 1'b1);
    for (int s = 0; s < 2 * FL; s++)
      feed($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    idle(3, 1'b1);

    // Downstream stall mid-frame
    do_start(0, 1'b1);
    feed(1, 2);
    feed(3, 4);
    for (int c = 0; c < 5; c++) step(1'b1, 5, 6, 1'b0, acc);
    feed(5, 6);
    idle(2, 1'b1);

    // Nonzero code index seeding
    do_start(5, 1'b1);
    for (int s = 0; s < 5; s++) feed(7 + s, -3 - s);
    idle(2, 1'b1);

    // Restart with an output pending, then reset while seeding
    do_start(0, 1'b1);
    feed(1, 1);
    feed(2, 2);
    do_start(0, 1'b0);
    feed(9, 9);
    do_start(20, 1'b1);
    idle(3, 1'b1);
    do_reset();
    idle(1, 1'b1);
    do_start(0, 1'b1);
    feed(10, 20);
    idle(1, 1'b1);

    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_start($urandom_range(0, 30), 1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 3) != 0,
             ($urandom_range(0, 7) == 0) ? -128
                                         : $urandom_range(0, 255) - 128,
             ($urandom_range(0, 7) == 0) ? -128
                                         : $urandom_range(0, 255) - 128,
             $urandom_range(0, 3) != 0, acc);
      end
    end
    idle(2, 1'b1);

    // Instance without auto restart returns to idle after the frame
    b2.i_start  = 1'b1;
    b2.i_code_n = 18'd2;
    @(posedge clk);
    #1;
    b2.i_start     = 1'b0;
    b2.i_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("d2_seed_rdy", b2.o_in_ready, 0);
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 3; c++) begin
      b2.i_in_valid = 1'b1;
      b2.i_in_i     = 8'(10 + c);
      b2.i_in_q     = 8'sd20;
      #1;
      chk("d2_run_rdy", b2.o_in_ready, 1);
      @(posedge clk);
      #1;
    end
    b2.i_in_valid = 1'b0;
    #1;
    e = model_out(12, 20, gold_rn(2, 2), 1'b1);
    chk("d2_valid", b2.o_out_valid, 1);
    chk("d2_last", b2.o_out_last, 1);
    chk("d2_busy", b2.o_busy, 0);
    chk("d2_idle_rdy", b2.o_in_ready, 0);
    chk("d2_rn", b2.o_out_rn, e.rn);
    chk("d2_i", b2.o_out_i, e.i);
    chk("d2_q", b2.o_out_q, e.q);
    @(posedge clk);
    #1;
    chk("d2_drained", b2.o_out_valid, 0);
    chk("d2_busy_hold", b2.o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
